// File: rtl/pulse_stretch_pkg.sv
// Shared types and constants for the LED pulse stretcher.
// State encoding plus the derivation of the phase-timer width.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Timer must hold values up to max(HOLD,GAP)-1.
    function automatic int cnt_width(input int hold, input int gap);
        return $clog2(max_int(hold, gap) + 1);
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Purpose: stretch 1-cycle events into fixed-length LED flashes with a dark gap, queueing repeats.
// Latency: event in IDLE -> led high on the next clock edge; queued events replay after each gap.
// Backpressure: none upstream; excess events saturate the pending counter and set sticky overflow.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int HOLD   = 5000000,
    parameter int GAP    = 2500000,
    parameter int PEND_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              evt,
    input  logic              clear,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int                CNT_W     = cnt_width(HOLD, GAP);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    timer, timer_nxt;
    logic [PEND_W-1:0]   pending_nxt;
    logic                overflow_nxt;
    logic                queue_evt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            timer    <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            led      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            pending  <= pending_nxt;
            overflow <= overflow_nxt;
            led      <= (state_nxt == ST_ON);
            busy     <= (state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        pending_nxt  = pending;
        overflow_nxt = overflow;
        queue_evt    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (evt) begin
                    state_nxt = ST_ON;
                    timer_nxt = '0;
                end
            end
            ST_ON: begin
                queue_evt = evt;
                if (timer == HOLD_LAST) begin
                    state_nxt = ST_GAP;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (timer == GAP_LAST) begin
                    timer_nxt = '0;
                    // An event on the final gap cycle either starts the flash directly
                    // or takes the slot freed by the replayed one, so it is never dropped.
                    if (pending != '0) begin
                        state_nxt   = ST_ON;
                        pending_nxt = pending - PEND_W'(1) + PEND_W'(evt);
                    end else if (evt) begin
                        state_nxt = ST_ON;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                    queue_evt = evt;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                timer_nxt = '0;
            end
        endcase

        if (queue_evt) begin
            if (pending == PEND_MAX) begin
                overflow_nxt = 1'b1;
            end else begin
                pending_nxt = pending + PEND_W'(1);
            end
        end

        if (clear) begin
            pending_nxt  = '0;
            overflow_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch with HOLD=4, GAP=3, PEND_W=2.
// Each vector row drives evt/clear for one clock and lists the outputs expected just after that edge.
module tb_pulse_stretch;

    logic       clock;
    logic       reset;
    logic       evt;
    logic       clear;
    logic       led;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    pulse_stretch #(
        .HOLD   (4),
        .GAP    (3),
        .PEND_W (2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .evt      (evt),
        .clear    (clear),
        .led      (led),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    typedef struct {
        bit e;
        bit c;
        bit l;
        bit b;
        int p;
        bit o;
    } row_t;

    row_t rows[$];
    int   passed = 0;
    int   total  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int idx, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s (row %0d): got %0d, expected %0d", name, idx, got, exp);
    endtask

    task automatic add(input bit e, input bit c, input bit l, input bit b, input int p, input bit o);
        row_t r;
        r.e = e; r.c = c; r.l = l; r.b = b; r.p = p; r.o = o;
        rows.push_back(r);
    endtask

    task automatic add_n(input int n, input bit e, input bit c, input bit l, input bit b,
                         input int p, input bit o);
        for (int k = 0; k < n; k++) add(e, c, l, b, p, o);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            evt   = rows[i].e;
            clear = rows[i].c;
            @(posedge clock);
            #1;
            evt   = 1'b0;
            clear = 1'b0;
            check("led",      i, int'(led),      int'(rows[i].l));
            check("busy",     i, int'(busy),     int'(rows[i].b));
            check("pending",  i, int'(pending),  rows[i].p);
            check("overflow", i, int'(overflow), int'(rows[i].o));
        end
    endtask

    initial begin
        int seg_a, seg_b, seg_c, seg_d, seg_end;

        // Single event: 4 cycles lit, 3 dark, then idle.
        seg_a = rows.size();
        add(1, 0, 1, 1, 0, 0);
        add_n(3, 0, 0, 1, 1, 0, 0);
        add_n(3, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0);

        // Four events during ON saturate the queue; three replays drain it.
        seg_b = rows.size();
        add(1, 0, 1, 1, 0, 0);
        add(1, 0, 1, 1, 1, 0);
        add(1, 0, 1, 1, 2, 0);
        add(1, 0, 1, 1, 3, 0);
        add(1, 0, 0, 1, 3, 1);
        add_n(2, 0, 0, 0, 1, 3, 1);
        for (int p = 2; p >= 0; p--) begin
            add(0, 0, 1, 1, p, 1);
            add_n(3, 0, 0, 1, 1, p, 1);
            add_n(3, 0, 0, 0, 1, p, 1);
        end
        add(0, 0, 0, 0, 0, 1);

        // event+clear in IDLE, then events on the final gap cycle, then clear mid-ON.
        seg_c = rows.size();
        add(1, 1, 1, 1, 0, 0);
        add_n(3, 0, 0, 1, 1, 0, 0);
        add_n(3, 0, 0, 0, 1, 0, 0);
        add(1, 0, 1, 1, 0, 0);
        add(1, 0, 1, 1, 1, 0);
        add(1, 0, 1, 1, 2, 0);
        add(0, 0, 1, 1, 2, 0);
        add_n(3, 0, 0, 0, 1, 2, 0);
        add(1, 0, 1, 1, 2, 0);
        add(1, 0, 1, 1, 3, 0);
        add(1, 0, 1, 1, 3, 1);
        add(0, 0, 1, 1, 3, 1);
        add_n(3, 0, 0, 0, 1, 3, 1);
        add(0, 0, 1, 1, 2, 1);
        add(0, 1, 1, 1, 0, 0);
        add_n(2, 0, 0, 1, 1, 0, 0);
        add_n(3, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0);

        // Build up pending=3 inside a flash before the asynchronous reset.
        seg_d = rows.size();
        add(1, 0, 1, 1, 0, 0);
        add(1, 0, 1, 1, 1, 0);
        add(1, 0, 1, 1, 2, 0);
        add(1, 0, 1, 1, 3, 0);
        seg_end = rows.size();

        reset = 1'b1;
        evt   = 1'b0;
        clear = 1'b0;
        #12;
        check("reset_led",      -1, int'(led),      0);
        check("reset_busy",     -1, int'(busy),     0);
        check("reset_pending",  -1, int'(pending),  0);
        check("reset_overflow", -1, int'(overflow), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        run_rows(seg_a, seg_b);
        run_rows(seg_b, seg_c);
        run_rows(seg_c, seg_d);
        run_rows(seg_d, seg_end);

        // Reset lands between clock edges while the LED is lit.
        #2;
        reset = 1'b1;
        #1;
        check("async_led",      -2, int'(led),      0);
        check("async_busy",     -2, int'(busy),     0);
        check("async_pending",  -2, int'(pending),  0);
        check("async_overflow", -2, int'(overflow), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        run_rows(seg_a, seg_b);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
